sr_tx_ctrl: RTL
===============

// Module: sr_tx_ctrl
// PURPOSE
//  Sequencer for the 4-bit load/shift register (right shift, s_in -> MSB, LSB is tap).
//  Accepts parallel words on a valid/ready port, drives the register's load enable,
//  parallel data and serial fill, and qualifies its LSB as a serial bit stream
//  (LSB first). Sits between a word producer and the serial link.
// PARAMETERS
//  WIDTH       4     data bits per word; equals the shift register width
//  GAP_CYCLES  1     idle cycles between words (0..15); 0 = back-to-back
//  FILL        1'b0  serial fill value driven on sr_s_in when not emitting parity
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      producer has a word
//  in_data    in   WIDTH  word to send
//  in_ready   out  1      controller can accept; transfer = in_valid & in_ready at posedge
//  sr_l_en    out  1      to shift register l_en (1 = load p_in, 0 = shift)
//  sr_p_in    out  WIDTH  to shift register p_in
//  sr_s_in    out  1      to shift register s_in_sr
//  sr_q0      in   1      shift register p_out[0]
//  ser_out    out  1      serial bit (= sr_q0 while ser_valid)
//  ser_valid  out  1      ser_out carries a word/parity bit this cycle
//  done       out  1      one-cycle pulse on last serial bit of a word
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, bit_cnt=0, gap_cnt=0, hold=0.
//    While in reset/after: in_ready=0 during reset cycle, sr_l_en=0, sr_p_in=0,
//    sr_s_in=FILL, ser_valid=0, done=0. Mid-operation reset drops the word in flight.
//  - Register shifts every cycle sr_l_en=0; controller owns timing, no hold state exists.
//  - FSM (registered state; outputs decoded from state/counters):
//    IDLE : in_ready=1. Transfer -> hold<=in_data, go LOAD. Else stay.
//    LOAD : one cycle, in_ready=0, sr_l_en=1, sr_p_in=hold. -> SHIFT, bit_cnt<=0.
//    SHIFT: NB cycles (NB=WIDTH, or WIDTH+1 with parity). ser_valid=1, ser_out=sr_q0,
//           sr_l_en=0. bit_cnt increments each cycle; done=1 when bit_cnt==NB-1.
//           At bit_cnt==NB-1: -> GAP (gap_cnt<=0) if GAP_CYCLES>0, else -> IDLE.
//    GAP  : ser_valid=0, in_ready=0; after GAP_CYCLES cycles -> IDLE.
//  - Latency: accept edge A; LOAD cycle after A; first ser_valid cycle 2 cycles after A
//    presents in_data[0]; bit k presented in SHIFT cycle k.
//  - Throughput: one word per WIDTH+2+GAP_CYCLES cycles (+1 with parity); IDLE always
//    lasts >=1 cycle.
//  - in_valid/in_data ignored outside IDLE; producer must hold until transfer.
//  - sr_p_in=hold in all states (only sampled in LOAD); sr_s_in=FILL unless parity.
//  - bit_cnt width = $clog2(WIDTH+2); no wrap beyond NB-1.
// CONFIGURATION
//  SR_TX_CTRL_PARITY_EN defined: NB=WIDTH+1; sr_s_in=^hold (even parity) in SHIFT
//    cycle 0, so the parity bit reaches sr_q0 in SHIFT cycle WIDTH; done on that cycle.
//  Not defined: NB=WIDTH; sr_s_in=FILL always; no parity bit emitted.
// TESTING
//  1 rst_n=0 two cycles with in_valid=1 -> in_ready=0,sr_l_en=0,ser_valid=0; after
//    release in_ready=1 next cycle, no transfer taken during reset.
//  2 in_data=4'b1011 one transfer -> sr_l_en=1 one cycle; ser_out 1,1,0,1 on 4
//    consecutive ser_valid cycles; done only on 4th; then 1 GAP cycle, IDLE.
//  3 in_valid held high with 4'h5 then 4'hA, GAP_CYCLES=1 -> second transfer exactly
//    7 cycles after first; in_ready=0 through LOAD/SHIFT/GAP; streams 1,0,1,0/0,1,0,1.
//  4 GAP_CYCLES=0, back-to-back words -> transfer every 6 cycles, no ser_valid gap
//    longer than 2 cycles (IDLE+LOAD).
//  5 rst_n=0 in SHIFT cycle 2 of 4'hF -> next cycle IDLE, ser_valid=0, done never
//    pulses for that word; next word 4'h3 sends 1,1,0,0 cleanly.
//  6 PARITY_EN, in_data=4'b0111 -> 5 ser_valid bits 1,1,1,0,1; done on 5th;
//    4'b0110 -> parity bit 0.

Source files
------------

// File: rtl/sr_tx_ctrl.sv
// ---------------------------------------------------------------------------------------------
// sr_tx_ctrl
//
// Sequencer for an external WIDTH-bit load/shift register. The register shifts right with
// s_in entering at the MSB, and its LSB is the serial tap. The controller accepts parallel
// words on a valid/ready port, loads each word into the register, and then qualifies the
// register LSB as a serial bit stream, LSB first.
//
// Word timing, with accept edge A:
//   LOAD  in the cycle after A
//   SHIFT for NB cycles; bit k is on ser_out in SHIFT cycle k
//   GAP   for GAP_CYCLES cycles, then IDLE for at least one cycle
//
// Parameters
//   WIDTH       data bits per word; equals the shift register width
//   GAP_CYCLES  idle cycles between words (0..15); 0 means back-to-back
//   FILL        serial fill value on sr_s_in when no parity bit is being injected
//
// Build option
//   SR_TX_CTRL_PARITY_EN  when defined, an even-parity bit follows the data bits
//                         (NB = WIDTH + 1). When undefined, NB = WIDTH.
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   producer has a word
//   in_data    in   word to send
//   in_ready   out  controller can accept; transfer = in_valid & in_ready at posedge
//   sr_l_en    out  shift register load enable (1 = load p_in, 0 = shift)
//   sr_p_in    out  shift register parallel input
//   sr_s_in    out  shift register serial input (enters at MSB)
//   sr_q0      in   shift register LSB
//   ser_out    out  serial bit, equals sr_q0 while ser_valid
//   ser_valid  out  ser_out carries a data or parity bit this cycle
//   done       out  one-cycle pulse on the last serial bit of a word
// ---------------------------------------------------------------------------------------------

module sr_tx_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic        FILL       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_l_en,
    output logic [WIDTH-1:0] sr_p_in,
    output logic             sr_s_in,
    input  logic             sr_q0,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

`ifdef SR_TX_CTRL_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif

    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam int unsigned GapW = 4;

    localparam logic [CntW-1:0] LastBit = CntW'(NB - 1);
    // When GAP_CYCLES is 0 the GAP state is never entered, so the wrapped value is harmless.
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            hold_q    <= hold_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        hold_d    = hold_q;

        unique case (state_q)
            StIdle: begin
                // in_ready is high throughout IDLE, so in_valid alone marks a transfer.
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                bit_cnt_d = '0;
                state_d   = StShift;
            end

            StShift: begin
                if (bit_cnt_q == LastBit) begin
                    // Counter parks on the last bit; LOAD clears it for the next word.
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------------------------
    // All outputs are forced to their idle values while rst_n is low, so a reset cycle never
    // accepts a word, loads the register or qualifies a serial bit.
    always_comb begin
        in_ready  = 1'b0;
        sr_l_en   = 1'b0;
        sr_p_in   = '0;
        sr_s_in   = FILL;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;

        if (rst_n) begin
            // Register only samples p_in during LOAD; driving hold everywhere keeps it static.
            sr_p_in = hold_q;

            unique case (state_q)
                StIdle: begin
                    in_ready = 1'b1;
                end

                StLoad: begin
                    sr_l_en = 1'b1;
                end

                StShift: begin
                    ser_valid = 1'b1;
                    ser_out   = sr_q0;
                    done      = (bit_cnt_q == LastBit);
`ifdef SR_TX_CTRL_PARITY_EN
                    // Parity enters the MSB at the end of SHIFT cycle 0 and therefore
                    // reaches the tap in SHIFT cycle WIDTH, right after the last data bit.
                    if (bit_cnt_q == '0) begin
                        sr_s_in = ^hold_q;
                    end
`endif
                end

                StGap: begin
                    // Outputs stay idle while the gap counter runs.
                end

                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule
